// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer and its alignment checker.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED,
    FAULT
  } pc_state_e;

  localparam int unsigned STEP_32 = 4;
  localparam int unsigned STEP_16 = 2;

  // Low address bits that must be zero for a legal instruction address.
  function automatic logic [1:0] align_mask(input logic compressed);
    return compressed ? 2'b01 : 2'b11;
  endfunction

endpackage

// File: rtl/pc_align_check.sv
// Combinational instruction-address alignment check, shared with the LSU.
module pc_align_check
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_target,
  input  logic             i_compressed,
  output logic             o_misaligned
);

  logic [WIDTH-1:0] w_mask;

  assign w_mask       = {{(WIDTH-2){1'b0}}, align_mask(i_compressed)};
  assign o_misaligned = |(i_target & w_mask);

endmodule

// File: rtl/pc_sequencer.sv
// RISC-V fetch-address sequencer: boot, sequential advance, redirect, trap, halt
// and misaligned-redirect fault handling with a valid/ready fetch request.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter bit               COMPRESSED   = 1'b0
) (
  input  logic             clk,
  input  logic             n_rst,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  input  logic             fetch_ready,
  input  logic             inst_is_16,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             trap_valid,
  input  logic [WIDTH-1:0] trap_vector,
  input  logic             halt,
  output logic             misaligned_exc,
  output logic [WIDTH-1:0] misaligned_addr
);

  localparam logic [WIDTH-1:0] TRAP_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

  pc_state_e        r_state, w_state_n;
  logic [WIDTH-1:0] r_pc, w_pc_n;
  logic [WIDTH-1:0] r_addr, w_addr_n;
  logic             r_exc, w_exc_n;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_trap_pc;
  logic             w_misaligned;

  pc_align_check #(
    .WIDTH(WIDTH)
  ) u_align (
    .i_target    (redirect_target),
    .i_compressed(COMPRESSED),
    .o_misaligned(w_misaligned)
  );

  assign w_step    = (COMPRESSED && inst_is_16) ? WIDTH'(STEP_16) : WIDTH'(STEP_32);
  assign w_trap_pc = trap_vector & TRAP_MASK;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= BOOT;
      r_pc    <= RESET_VECTOR;
      r_exc   <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_exc   <= w_exc_n;
      r_addr  <= w_addr_n;
    end
  end

  // Trap is hoisted out of the state case: it wins from every state except BOOT.
  always_comb begin
    w_state_n = r_state;
    w_pc_n    = r_pc;
    w_exc_n   = 1'b0;
    w_addr_n  = r_addr;
    if (trap_valid && (r_state != BOOT)) begin
      w_state_n = RUN;
      w_pc_n    = w_trap_pc;
    end else begin
      case (r_state)
        BOOT:   w_state_n = RUN;
        RUN: begin
          if (redirect_valid) begin
            if (w_misaligned) begin
              w_state_n = FAULT;
              w_exc_n   = 1'b1;
              w_addr_n  = redirect_target;
            end else begin
              w_pc_n = redirect_target;
            end
          end else if (halt) begin
            w_state_n = HALTED;
          end else if (fetch_ready) begin
            w_pc_n = r_pc + w_step;
          end
        end
        HALTED: if (!halt) w_state_n = RUN;
        FAULT:  w_state_n = FAULT;
        default: w_state_n = BOOT;
      endcase
    end
  end

  assign pc              = r_pc;
  assign pc_valid        = (r_state == RUN);
  assign misaligned_exc  = r_exc;
  assign misaligned_addr = r_addr;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: three configurations checked against a rule-level model.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: W32 RV=0x100 C=0, 1: W32 RV=0 C=1, 2: W16 RV=0xFFF0 C=0
  int unsigned P_W [3] = '{32, 32, 16};
  bit          P_C [3] = '{1'b0, 1'b1, 1'b0};
  logic [31:0] P_RV[3] = '{32'h100, 32'h0, 32'hFFF0};

  logic        fr[3], i16[3], rdv[3], trv[3], hlt[3];
  logic [31:0] rt[3], tv[3];
  logic        pv[3], me[3];
  logic [31:0] pc0, pc1, ma0, ma1;
  logic [15:0] pc2, ma2;
  logic [31:0] o_pc[3], o_ma[3];

  always_comb begin
    o_pc[0] = pc0; o_pc[1] = pc1; o_pc[2] = {16'h0, pc2};
    o_ma[0] = ma0; o_ma[1] = ma1; o_ma[2] = {16'h0, ma2};
  end

  pc_sequencer #(.WIDTH(32), .RESET_VECTOR(32'h100), .COMPRESSED(1'b0)) u_c0 (
    .clk(clk), .n_rst(n_rst), .pc(pc0), .pc_valid(pv[0]), .fetch_ready(fr[0]),
    .inst_is_16(i16[0]), .redirect_valid(rdv[0]), .redirect_target(rt[0]),
    .trap_valid(trv[0]), .trap_vector(tv[0]), .halt(hlt[0]),
    .misaligned_exc(me[0]), .misaligned_addr(ma0));

  pc_sequencer #(.WIDTH(32), .RESET_VECTOR(32'h0), .COMPRESSED(1'b1)) u_c1 (
    .clk(clk), .n_rst(n_rst), .pc(pc1), .pc_valid(pv[1]), .fetch_ready(fr[1]),
    .inst_is_16(i16[1]), .redirect_valid(rdv[1]), .redirect_target(rt[1]),
    .trap_valid(trv[1]), .trap_vector(tv[1]), .halt(hlt[1]),
    .misaligned_exc(me[1]), .misaligned_addr(ma1));

  pc_sequencer #(.WIDTH(16), .RESET_VECTOR(16'hFFF0), .COMPRESSED(1'b0)) u_w16 (
    .clk(clk), .n_rst(n_rst), .pc(pc2), .pc_valid(pv[2]), .fetch_ready(fr[2]),
    .inst_is_16(i16[2]), .redirect_valid(rdv[2]), .redirect_target(rt[2][15:0]),
    .trap_valid(trv[2]), .trap_vector(tv[2][15:0]), .halt(hlt[2]),
    .misaligned_exc(me[2]), .misaligned_addr(ma2));

  // Reference model: mode 0=booting, 1=fetching, 2=halted, 3=faulted
  int          m_mode[3];
  logic [31:0] m_pc[3], m_addr[3];
  logic        m_exc[3];
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_mode[k] = 0; m_pc[k] = P_RV[k]; m_addr[k] = 0; m_exc[k] = 1'b0;
    end
  endfunction

  function automatic void model_step(int k);
    longint unsigned modulus = 64'd1 << P_W[k];
    longint unsigned align = P_C[k] ? 2 : 4;
    longint unsigned tgt = rt[k] % modulus;
    m_exc[k] = 1'b0;
    if (m_mode[k] == 0) begin
      m_mode[k] = 1;
    end else if (trv[k]) begin
      m_pc[k] = 32'((tv[k] % modulus) / 4 * 4);
      m_mode[k] = 1;
    end else if (m_mode[k] == 1) begin
      if (rdv[k]) begin
        if (tgt % align != 0) begin
          m_exc[k] = 1'b1; m_addr[k] = 32'(tgt); m_mode[k] = 3;
        end else begin
          m_pc[k] = 32'(tgt);
        end
      end else if (hlt[k]) begin
        m_mode[k] = 2;
      end else if (fr[k]) begin
        m_pc[k] = 32'((m_pc[k] + ((P_C[k] && i16[k]) ? 2 : 4)) % modulus);
      end
    end else if (m_mode[k] == 2 && !hlt[k]) begin
      m_mode[k] = 1;
    end
  endfunction

  task automatic idle();
    for (int k = 0; k < 3; k++) begin
      fr[k] = 0; i16[k] = 0; rdv[k] = 0; trv[k] = 0; hlt[k] = 0; rt[k] = 0; tv[k] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (n_rst) for (int k = 0; k < 3; k++) model_step(k);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (o_pc[k] !== P_RV[k] || pv[k] !== 1'b0 || me[k] !== 1'b0 || o_ma[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset k=%0d got pc=%h v=%b e=%b a=%h exp pc=%h v=0 e=0 a=0",
                 k, o_pc[k], pv[k], me[k], o_ma[k], P_RV[k]);
      end
    end
    n_rst = 1'b1;
    n_chk++;
    if (o_pc[0] !== 32'h100 || pv[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL cycle0 got pc=%h v=%b exp pc=00000100 v=0", o_pc[0], pv[0]);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (pv[k] !== 1'b1 || o_pc[k] !== P_RV[k]) begin
        n_fail++;
        $display("FAIL boot k=%0d got pc=%h v=%b exp pc=%h v=1", k, o_pc[k], pv[k], P_RV[k]);
      end
    end
  endtask

  task automatic test_advance();
    logic [31:0] exp_pc;
    exp_pc = 32'h100;
    for (int i = 0; i < 4; i++) begin
      fr[0] = 1'b1;
      tick();
      exp_pc = exp_pc + 4;
      n_chk++;
      if (o_pc[0] !== exp_pc || o_pc[0] !== m_pc[0]) begin
        n_fail++;
        $display("FAIL advance got=%h exp=%h", o_pc[0], exp_pc);
      end
    end
    fr[0] = 1'b0;
    repeat (3) begin
      tick();
      n_chk++;
      if (o_pc[0] !== 32'h110 || pv[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold got pc=%h v=%b exp pc=00000110 v=1", o_pc[0], pv[0]);
      end
    end
  endtask

  task automatic test_redirect_trap();
    rdv[0] = 1'b1; rt[0] = 32'h2000;
    tick();
    n_chk++;
    if (o_pc[0] !== 32'h2000) begin
      n_fail++; $display("FAIL redirect got=%h exp=00002000", o_pc[0]);
    end
    rt[0] = 32'h3000; trv[0] = 1'b1; tv[0] = 32'h8003;
    tick();
    idle();
    n_chk++;
    if (o_pc[0] !== 32'h8000 || me[0] !== 1'b0 || pv[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL trap_over_redirect got pc=%h e=%b v=%b exp pc=00008000 e=0 v=1", o_pc[0], me[0], pv[0]);
    end
  endtask

  task automatic test_misaligned();
    rdv[0] = 1'b1; rt[0] = 32'h1002;
    tick();
    idle();
    n_chk++;
    if (me[0] !== 1'b1 || o_ma[0] !== 32'h1002 || pv[0] !== 1'b0 || o_pc[0] !== 32'h8000) begin
      n_fail++;
      $display("FAIL misaligned got e=%b a=%h v=%b pc=%h exp e=1 a=00001002 v=0 pc=00008000",
               me[0], o_ma[0], pv[0], o_pc[0]);
    end
    rdv[0] = 1'b1; rt[0] = 32'h4000;
    tick();
    idle();
    n_chk++;
    if (me[0] !== 1'b0 || o_ma[0] !== 32'h1002 || o_pc[0] !== 32'h8000 || pv[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_hold got e=%b a=%h pc=%h v=%b exp e=0 a=00001002 pc=00008000 v=0",
               me[0], o_ma[0], o_pc[0], pv[0]);
    end
    trv[0] = 1'b1; tv[0] = 32'h40;
    tick();
    idle();
    n_chk++;
    if (o_pc[0] !== 32'h40 || pv[0] !== 1'b1) begin
      n_fail++; $display("FAIL fault_exit got pc=%h v=%b exp pc=00000040 v=1", o_pc[0], pv[0]);
    end
    rdv[1] = 1'b1; rt[1] = 32'h1002;
    tick();
    n_chk++;
    if (o_pc[1] !== 32'h1002 || me[1] !== 1'b0) begin
      n_fail++; $display("FAIL c_half_aligned got pc=%h e=%b exp pc=00001002 e=0", o_pc[1], me[1]);
    end
    rt[1] = 32'h1001;
    tick();
    idle();
    n_chk++;
    if (me[1] !== 1'b1 || o_ma[1] !== 32'h1001 || o_pc[1] !== 32'h1002) begin
      n_fail++;
      $display("FAIL c_odd got e=%b a=%h pc=%h exp e=1 a=00001001 pc=00001002", me[1], o_ma[1], o_pc[1]);
    end
    trv[1] = 1'b1; tv[1] = 32'h0;
    tick();
    idle();
  endtask

  task automatic test_compressed();
    logic [31:0] exp_c1[3];
    logic        pat[3];
    exp_c1 = '{32'h2, 32'h6, 32'h8};
    pat    = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      fr[1] = 1'b1; i16[1] = pat[i];
      fr[0] = (i == 0); i16[0] = 1'b1;
      tick();
      n_chk++;
      if (o_pc[1] !== exp_c1[i]) begin
        n_fail++; $display("FAIL c_step%0d got=%h exp=%h", i, o_pc[1], exp_c1[i]);
      end
    end
    idle();
    n_chk++;
    if (o_pc[0] !== 32'h44) begin
      n_fail++; $display("FAIL nc_step16 got=%h exp=00000044", o_pc[0]);
    end
  endtask

  task automatic test_halt_wrap();
    hlt[0] = 1'b1;
    tick();
    n_chk++;
    if (pv[0] !== 1'b0 || o_pc[0] !== 32'h44) begin
      n_fail++; $display("FAIL halt got v=%b pc=%h exp v=0 pc=00000044", pv[0], o_pc[0]);
    end
    fr[0] = 1'b1; rdv[0] = 1'b1; rt[0] = 32'h900;
    tick();
    idle();
    hlt[0] = 1'b0;
    n_chk++;
    if (pv[0] !== 1'b0 || o_pc[0] !== 32'h44) begin
      n_fail++; $display("FAIL halted_ignores got v=%b pc=%h exp v=0 pc=00000044", pv[0], o_pc[0]);
    end
    tick();
    n_chk++;
    if (pv[0] !== 1'b1 || o_pc[0] !== 32'h44) begin
      n_fail++; $display("FAIL resume got v=%b pc=%h exp v=1 pc=00000044", pv[0], o_pc[0]);
    end
    hlt[0] = 1'b1; rdv[0] = 1'b1; rt[0] = 32'h500;
    tick();
    rdv[0] = 1'b0;
    n_chk++;
    if (pv[0] !== 1'b1 || o_pc[0] !== 32'h500) begin
      n_fail++; $display("FAIL redirect_over_halt got v=%b pc=%h exp v=1 pc=00000500", pv[0], o_pc[0]);
    end
    tick();
    n_chk++;
    if (pv[0] !== 1'b0 || o_pc[0] !== 32'h500) begin
      n_fail++; $display("FAIL halt_after got v=%b pc=%h exp v=0 pc=00000500", pv[0], o_pc[0]);
    end
    idle();
    tick();
    rdv[2] = 1'b1; rt[2] = 32'hFFFC;
    tick();
    idle();
    fr[2] = 1'b1;
    tick();
    idle();
    n_chk++;
    if (o_pc[2] !== 32'h0 || pv[2] !== 1'b1) begin
      n_fail++; $display("FAIL wrap16 got pc=%h v=%b exp pc=00000000 v=1", o_pc[2], pv[2]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        fr[k]  = ($urandom_range(3) != 0);
        i16[k] = $urandom_range(1) != 0;
        rdv[k] = ($urandom_range(9) == 0);
        trv[k] = ($urandom_range(19) == 0);
        hlt[k] = ($urandom_range(9) == 0);
        rt[k]  = $urandom;
        if ($urandom_range(2) != 0) rt[k][1:0] = 2'b00;
        tv[k]  = $urandom;
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (o_pc[k] !== m_pc[k] || pv[k] !== (m_mode[k] == 1) || me[k] !== m_exc[k] ||
            o_ma[k] !== m_addr[k]) begin
          n_fail++;
          $display("FAIL random c=%0d k=%0d got pc=%h v=%b e=%b a=%h exp pc=%h v=%b e=%b a=%h",
                   c, k, o_pc[k], pv[k], me[k], o_ma[k], m_pc[k], m_mode[k] == 1, m_exc[k], m_addr[k]);
        end
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    trv[0] = 1'b1; tv[0] = 32'h0;
    tick();
    idle();
    rdv[0] = 1'b1; rt[0] = 32'h1;
    tick();
    idle();
    n_chk++;
    if (me[0] !== 1'b1 || pv[0] !== 1'b0) begin
      n_fail++; $display("FAIL enter_fault got e=%b v=%b exp e=1 v=0", me[0], pv[0]);
    end
    #2 n_rst = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (o_pc[k] !== P_RV[k] || pv[k] !== 1'b0 || me[k] !== 1'b0 || o_ma[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL async_reset k=%0d got pc=%h v=%b e=%b a=%h exp pc=%h v=0 e=0 a=0",
                 k, o_pc[k], pv[k], me[k], o_ma[k], P_RV[k]);
      end
    end
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    n_chk++;
    if (pv[0] !== 1'b1 || o_pc[0] !== 32'h100) begin
      n_fail++; $display("FAIL reboot got v=%b pc=%h exp v=1 pc=00000100", pv[0], o_pc[0]);
    end
  endtask

  initial begin
    test_reset();
    test_advance();
    test_redirect_trap();
    test_misaligned();
    test_compressed();
    test_halt_wrap();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
